// File: rtl/ram_scan_system_if.sv
// rtl/ram_scan_system_if.sv - user write, clear, hold and scan-read signals of ram_scan_system
interface ram_scan_system_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clear_req;
    logic              hold;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, clear_req, hold,
        input  rd_addr, rd_data, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clear_req, hold,
        output rd_addr, rd_data, busy
    );
endinterface

// File: rtl/ram_scan_system.sv
// rtl/ram_scan_system.sv - RAM with user write port, auto-scanning read port and clear FSM
module ram_scan_system #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 5,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    ram_scan_system_if.slave bus
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SCAN_DIV - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              busy_q;
    logic              clear_q;
    logic [TICK_W-1:0] tick_q;
    logic [ADDR_W-1:0] scan_addr_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              clear_edge;

    assign clear_edge = bus.clear_req & ~clear_q;

    // The clear engine owns the write port while active; user writes are dropped.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = bus.wr_addr;
        mem_wdata_d = bus.wr_data;
        if (state_q == CLEAR) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clr_addr_q;
            mem_wdata_d = '0;
        end else if (bus.wr_en) begin
            mem_we_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            clear_q <= bus.clear_req;
            case (state_q)
                IDLE: begin
                    if (clear_edge) begin
                        state_q    <= CLEAR;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q      <= '0;
            scan_addr_q <= '0;
        end else if (!bus.hold) begin
            if (tick_q == TICK_MAX) begin
                tick_q      <= '0;
                scan_addr_q <= scan_addr_q + 1'b1;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

    // Write-first: a same-cycle write to the scanned address is forwarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_addr_q <= scan_addr_q;
            if (mem_we_d && (mem_waddr_d == scan_addr_q)) begin
                rd_data_q <= mem_wdata_d;
            end else begin
                rd_data_q <= mem_q[scan_addr_q];
            end
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.rd_data = rd_data_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_ram_scan_system.sv
// tb/tb_ram_scan_system.sv - directed and randomized checks of ram_scan_system against a behavioural model
module tb_ram_scan_system;
    localparam int DW    = 4;
    localparam int AW    = 5;
    localparam int SD    = 4;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic reset_n;

    ram_scan_system_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_scan_system #(.DATA_W(DW), .ADDR_W(AW), .SCAN_DIV(SD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: scan position derives from the count of un-held edges.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    longint        adv;
    bit            m_clr;
    int            m_cnt;
    bit            m_prev;
    int            busy_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_scan();
        return int'((adv / SD) % DEPTH);
    endfunction

    task automatic step();
        int            cur;
        bit            we;
        int            wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_d;
        bit            exp_k;
        cur = model_scan();
        we  = 0;
        wa  = 0;
        wd  = '0;
        if (m_clr) begin
            we = 1; wa = m_cnt; wd = '0;
        end else if (bus.wr_en) begin
            we = 1; wa = int'(bus.wr_addr); wd = bus.wr_data;
        end
        if (we && wa == cur) begin
            exp_k = 1; exp_d = wd;
        end else begin
            exp_k = m_known[cur]; exp_d = m_mem[cur];
        end
        if (we) begin
            m_mem[wa] = wd; m_known[wa] = 1;
        end
        if (m_clr) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_clr = 0;
        end else if (bus.clear_req && !m_prev) begin
            m_clr = 1; m_cnt = 0;
        end
        m_prev = bus.clear_req;
        if (!bus.hold) adv++;
        @(posedge clk);
        #1;
        chk("rd_addr", 32'(bus.rd_addr), 32'(cur));
        chk("busy", 32'(bus.busy), 32'(m_clr));
        if (exp_k) chk("rd_data", 32'(bus.rd_data), 32'(exp_d));
        if (bus.busy === 1'b1) busy_seen++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        adv = 0; m_clr = 0; m_cnt = 0; m_prev = 0;
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_until_scan(input int target);
        int n;
        n = 0;
        while (model_scan() != target && n < 4 * DEPTH * SD) begin
            step();
            n++;
        end
        if (model_scan() != target) begin
            tests++;
            fails++;
            $error("FAIL until_scan got=%0d exp=%0d", model_scan(), target);
        end
    endtask

    initial begin
        int b0;
        logic [DW-1:0] v20;
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 0;
            m_mem[i]   = '0;
        end
        adv = 0; m_clr = 0; m_cnt = 0; m_prev = 0; busy_seen = 0;
        reset_n = 1'b0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clear_req = 0; bus.hold = 0;

        #12;
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        #4 reset_n = 1'b1;

        // Reset then clear
        bus.clear_req = 1;
        b0 = busy_seen;
        step();
        bus.clear_req = 0;
        for (int i = 0; i < DEPTH + 4; i++) step();
        chk("clear_busy_len", 32'(busy_seen - b0), 32'(DEPTH));
        for (int i = 0; i < DEPTH * SD; i++) begin
            step();
            chk("swept_zero", 32'(bus.rd_data), 32'd0);
        end

        // Write/scan
        bus.wr_en = 1; bus.wr_addr = 5'd1;  bus.wr_data = 4'h2; step();
        bus.wr_addr = 5'd10; bus.wr_data = 4'h9; step();
        bus.wr_en = 0;
        for (int i = 0; i < DEPTH * SD + 8; i++) step();

        // Hold at address 5
        run_until_scan(5);
        step();
        step();
        bus.hold = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_addr", 32'(bus.rd_addr), 32'd5);
        end
        bus.hold = 0;
        for (int i = 0; i < 3 * SD; i++) step();

        // Bypass at held address 7
        run_until_scan(7);
        bus.hold = 1;
        step();
        bus.wr_en = 1; bus.wr_addr = 5'd7; bus.wr_data = 4'hC;
        step();
        chk("bypass_data", 32'(bus.rd_data), 32'hC);
        bus.wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bypass_stable", 32'(bus.rd_data), 32'hC);
        end
        bus.hold = 0;

        // Randomized traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            bus.wr_en     = ($urandom_range(0, 2) == 0);
            bus.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_data   = DW'($urandom);
            bus.hold      = ($urandom_range(0, 5) == 0);
            bus.clear_req = ($urandom_range(0, 60) == 0) ? 1'b1 : (bus.clear_req & ($urandom_range(0, 3) != 0));
            step();
        end
        bus.wr_en = 0; bus.hold = 0; bus.clear_req = 0;
        for (int i = 0; i < DEPTH + 2; i++) step();

        // Clear arbitration, edge on exit cycle, held request
        bus.clear_req = 1;
        step();
        bus.clear_req = 0;
        bus.wr_en = 1; bus.wr_addr = 5'd3; bus.wr_data = 4'hF;
        for (int i = 0; i < 8; i++) step();
        bus.wr_en = 0;
        while (m_clr && m_cnt < DEPTH - 1) step();
        bus.clear_req = 1;
        step();
        b0 = busy_seen;
        for (int i = 0; i < 40; i++) step();
        chk("no_retrigger", 32'(busy_seen - b0), 32'd0);
        run_until_scan(3);
        step();
        chk("arb_mem3", 32'(bus.rd_data), 32'd0);
        bus.clear_req = 0;
        step();

        // Reset mid-clear
        bus.wr_en = 1; bus.wr_addr = 5'd20; bus.wr_data = 4'h7; v20 = 4'h7;
        step();
        bus.wr_en = 0;
        bus.clear_req = 1;
        step();
        bus.clear_req = 0;
        for (int i = 0; i < 10; i++) step();
        do_reset();
        for (int i = 0; i < DEPTH * SD; i++) step();
        run_until_scan(20);
        step();
        chk("keep_20", 32'(bus.rd_data), 32'(v20));
        run_until_scan(4);
        step();
        chk("zeroed_4", 32'(bus.rd_data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
